// File: rtl/nco.sv
// rtl/nco.sv - 8-bit NCO with registered sine/cosine outputs from a quarter-wave table
module nco (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] phase_inc,
  output logic [7:0] sine_out,
  output logic [7:0] cosine_out
);

  logic [7:0] phase;
  logic [7:0] sine_next;
  logic [7:0] cosine_next;

  // First quadrant magnitude: round(127*sin(pi*idx/128)) for idx 0..64,
  // rounded half away from zero. Indices above 64 are never addressed.
  function automatic logic [6:0] quarter(input logic [6:0] idx);
    case (idx)
      7'd0:  quarter = 7'd0;
      7'd1:  quarter = 7'd3;
      7'd2:  quarter = 7'd6;
      7'd3:  quarter = 7'd9;
      7'd4:  quarter = 7'd12;
      7'd5:  quarter = 7'd16;
      7'd6:  quarter = 7'd19;
      7'd7:  quarter = 7'd22;
      7'd8:  quarter = 7'd25;
      7'd9:  quarter = 7'd28;
      7'd10: quarter = 7'd31;
      7'd11: quarter = 7'd34;
      7'd12: quarter = 7'd37;
      7'd13: quarter = 7'd40;
      7'd14: quarter = 7'd43;
      7'd15: quarter = 7'd46;
      7'd16: quarter = 7'd49;
      7'd17: quarter = 7'd51;
      7'd18: quarter = 7'd54;
      7'd19: quarter = 7'd57;
      7'd20: quarter = 7'd60;
      7'd21: quarter = 7'd63;
      7'd22: quarter = 7'd65;
      7'd23: quarter = 7'd68;
      7'd24: quarter = 7'd71;
      7'd25: quarter = 7'd73;
      7'd26: quarter = 7'd76;
      7'd27: quarter = 7'd78;
      7'd28: quarter = 7'd81;
      7'd29: quarter = 7'd83;
      7'd30: quarter = 7'd85;
      7'd31: quarter = 7'd88;
      7'd32: quarter = 7'd90;
      7'd33: quarter = 7'd92;
      7'd34: quarter = 7'd94;
      7'd35: quarter = 7'd96;
      7'd36: quarter = 7'd98;
      7'd37: quarter = 7'd100;
      7'd38: quarter = 7'd102;
      7'd39: quarter = 7'd104;
      7'd40: quarter = 7'd106;
      7'd41: quarter = 7'd107;
      7'd42: quarter = 7'd109;
      7'd43: quarter = 7'd111;
      7'd44: quarter = 7'd112;
      7'd45: quarter = 7'd113;
      7'd46: quarter = 7'd115;
      7'd47: quarter = 7'd116;
      7'd48: quarter = 7'd117;
      7'd49: quarter = 7'd118;
      7'd50: quarter = 7'd120;
      7'd51: quarter = 7'd121;
      7'd52: quarter = 7'd122;
      7'd53: quarter = 7'd122;
      7'd54: quarter = 7'd123;
      7'd55: quarter = 7'd124;
      7'd56: quarter = 7'd125;
      7'd57: quarter = 7'd125;
      7'd58: quarter = 7'd126;
      7'd59: quarter = 7'd126;
      7'd60: quarter = 7'd126;
      7'd61: quarter = 7'd127;
      7'd62: quarter = 7'd127;
      7'd63: quarter = 7'd127;
      default: quarter = 7'd127;
    endcase
  endfunction

  // Full-wave offset-binary sample built from the quarter table by symmetry:
  // bit 6 mirrors the index within a half period, bit 7 flips the sign.
  function automatic logic [7:0] sample(input logic [7:0] p);
    logic [6:0] idx;
    logic [6:0] mag;
    idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    mag = quarter(idx);
    sample = p[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
  endfunction

  // Table lookup on the current (pre-update) accumulator; cosine leads by a quarter turn
  always_comb begin
    sine_next   = sample(phase);
    cosine_next = sample(phase + 8'd64);
  end

  // Accumulate phase and register both samples; reset forces phase 0 outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= 8'd0;
      sine_out   <= 8'd128;
      cosine_out <= 8'd255;
    end else begin
      phase      <= phase + phase_inc;
      sine_out   <= sine_next;
      cosine_out <= cosine_next;
    end
  end

endmodule

// File: tb/tb_nco.sv
// tb/tb_nco.sv - scoreboard testbench for nco against a real-arithmetic sine model
module tb_nco;

  logic       clk;
  logic       reset;
  logic [7:0] phase_inc;
  logic [7:0] sine_out;
  logic [7:0] cosine_out;

  nco dut (
    .clk        (clk),
    .reset      (reset),
    .phase_inc  (phase_inc),
    .sine_out   (sine_out),
    .cosine_out (cosine_out)
  );

  typedef struct {
    int s;
    int c;
    int ph;
    bit rec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  int   model_phase;
  bit   sweep_on;
  int   obs[256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sample straight from the formula, rounding half away from zero
  function automatic int ref_s(input int p);
    real v;
    v = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 256.0);
    if (v >= 0.0) return 128 + int'($floor(v + 0.5));
    else          return 128 - int'($floor(-v + 0.5));
  endfunction

  function automatic int ref_c(input int p);
    return ref_s((p + 64) % 256);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive the increment, predict the sample the next edge shows
  task automatic step(input int inc);
    exp_t e;
    phase_inc = inc[7:0];
    e.s   = ref_s(model_phase);
    e.c   = ref_c(model_phase);
    e.ph  = model_phase;
    e.rec = sweep_on;
    exp_q.push_back(e);
    model_phase = (model_phase + inc) % 256;
    @(negedge clk);
  endtask

  // Reset asserted at a falling edge, checked immediately, released two clocks later
  task automatic apply_reset();
    reset = 1'b1;
    model_phase = 0;
    #1;
    chk("reset_sine", sine_out, 128);
    chk("reset_cosine", cosine_out, 255);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every active edge out of reset, pop the prediction and compare
  always @(posedge clk) begin
    #1;
    if (!reset && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk($sformatf("sine_ph%0d", mon_e.ph), sine_out, mon_e.s);
      chk($sformatf("cosine_ph%0d", mon_e.ph), cosine_out, mon_e.c);
      if (mon_e.rec) obs[mon_e.ph] = sine_out;
    end
  end

  initial begin
    int run_inc;
    int run_len;
    checks      = 0;
    errors      = 0;
    model_phase = 0;
    sweep_on    = 1'b0;
    for (int i = 0; i < 256; i++) obs[i] = -1;

    // Reset held for five clocks with the increment undriven
    reset     = 1'b1;
    phase_inc = 8'bx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_reset_sine", sine_out, 128);
      chk("hold_reset_cosine", cosine_out, 255);
      chk("hold_reset_phase", dut.phase, 0);
    end
    reset = 1'b0;

    // Unit increment through a full wrap
    for (int i = 0; i < 260; i++) step(1);

    // Half rate
    apply_reset();
    for (int i = 0; i < 8; i++) step(8'h80);

    // Quarter rate, then retune to 0x10 sampled at the edge showing 255
    apply_reset();
    for (int i = 0; i < 5; i++) step(8'h40);
    for (int i = 0; i < 6; i++) step(8'h10);

    // Hold with zero increment
    for (int i = 0; i < 6; i++) step(0);

    // Asynchronous reset mid-run, between clock edges
    apply_reset();
    for (int i = 0; i < 100; i++) step(1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_phase = 0;
    #1;
    chk("async_reset_sine", sine_out, 128);
    chk("async_reset_cosine", cosine_out, 255);
    chk("async_reset_phase", dut.phase, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1);

    // Exhaustive sweep with observed samples recorded per phase
    apply_reset();
    sweep_on = 1'b1;
    for (int i = 0; i < 256; i++) step(1);
    sweep_on = 1'b0;

    // Randomized increments with random run lengths, occasionally zero
    for (int r = 0; r < 40; r++) begin
      run_inc = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      run_len = int'($urandom_range(1, 8));
      for (int i = 0; i < run_len; i++) step(run_inc);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    chk("anchor_s0", obs[0], 128);
    chk("anchor_s16", obs[16], 177);
    chk("anchor_s32", obs[32], 218);
    chk("anchor_s64", obs[64], 255);
    chk("anchor_s128", obs[128], 128);
    chk("anchor_s192", obs[192], 1);
    chk("anchor_s224", obs[224], 38);
    for (int p = 0; p < 128; p++)
      chk($sformatf("odd_symmetry_p%0d", p), obs[p] + obs[p + 128], 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
